// File: rtl/ex_mem_hilo_if.sv
// EX/MEM boundary bus: EX-side request signals, pipeline control and MEM-side/HI-LO results.
interface ex_mem_hilo_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [5:0]        stall_i;
  logic              flush_i;
  logic [DATA_W-1:0] ex_reg_i;
  logic [ADDR_W-1:0] ex_reg_w_addr_i;
  logic              ex_reg_w_en_i;
  logic              ex_hilo_w_en_i;
  logic              ex_hilo_w_addr_i;
  logic              hilo_rd_sel_i;
  logic [DATA_W-1:0] hilo_rdata_o;
  logic [DATA_W-1:0] mem_reg_o;
  logic [ADDR_W-1:0] mem_reg_w_addr_o;
  logic              mem_reg_w_en_o;
  logic              mem_valid_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output stall_i, flush_i, ex_reg_i, ex_reg_w_addr_i, ex_reg_w_en_i,
           ex_hilo_w_en_i, ex_hilo_w_addr_i, hilo_rd_sel_i,
    input  hilo_rdata_o, mem_reg_o, mem_reg_w_addr_o, mem_reg_w_en_o,
           mem_valid_o, hi_o, lo_o
  );

  modport slave (
    input  stall_i, flush_i, ex_reg_i, ex_reg_w_addr_i, ex_reg_w_en_i,
           ex_hilo_w_en_i, ex_hilo_w_addr_i, hilo_rd_sel_i,
    output hilo_rdata_o, mem_reg_o, mem_reg_w_addr_o, mem_reg_w_en_o,
           mem_valid_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_mem_hilo.sv
// EX->MEM pipeline register that also owns the architectural HI/LO pair.
// HI/LO commit on the EX->MEM capture edge; reads back to EX are combinational.
module ex_mem_hilo #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter logic [DATA_W-1:0] HILO_RST = '0
) (
  input logic          clk,
  input logic          rst_n,
  ex_mem_hilo_if.slave bus
);

  logic [DATA_W-1:0] mem_reg_q, mem_reg_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic capture_c;
  logic bubble_c;
  logic hilo_commit_c;
  logic unused_stall_c;

  // Only the EX (bit3) and MEM (bit4) stall bits matter at this boundary.
  assign unused_stall_c = ^{bus.stall_i[5], bus.stall_i[2:0]};

  assign bubble_c      = bus.flush_i | (bus.stall_i[3] & ~bus.stall_i[4]);
  assign capture_c     = ~bus.flush_i & ~bus.stall_i[3];
  assign hilo_commit_c = capture_c & bus.ex_hilo_w_en_i;

  always_comb begin
    mem_reg_d   = mem_reg_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_valid_d = mem_valid_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    if (bubble_c) begin
      mem_reg_d   = '0;
      mem_addr_d  = '0;
      mem_we_d    = 1'b0;
      mem_valid_d = 1'b0;
    end else if (capture_c) begin
      mem_reg_d   = bus.ex_reg_i;
      mem_addr_d  = bus.ex_reg_w_addr_i;
      mem_we_d    = bus.ex_reg_w_en_i;
      mem_valid_d = 1'b1;
    end

    // HI/LO writes never alias onto the GPR write enable.
    if (hilo_commit_c) begin
      if (bus.ex_hilo_w_addr_i) hi_d = bus.ex_reg_i;
      else                      lo_d = bus.ex_reg_i;
    end
  end

  // rst_n is active-high and synchronous here.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_reg_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      hi_q        <= HILO_RST;
      lo_q        <= HILO_RST;
    end else begin
      mem_reg_q   <= mem_reg_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_valid_q <= mem_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign bus.mem_reg_o        = mem_reg_q;
  assign bus.mem_reg_w_addr_o = mem_addr_q;
  assign bus.mem_reg_w_en_o   = mem_we_q;
  assign bus.mem_valid_o      = mem_valid_q;
  assign bus.hi_o             = hi_q;
  assign bus.lo_o             = lo_q;
  assign bus.hilo_rdata_o     = bus.hilo_rd_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_ex_mem_hilo.sv
// Scoreboard bench for ex_mem_hilo: each driven cycle pushes its expected
// post-edge state, which is popped and compared once the edge has passed.
module tb_ex_mem_hilo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              valid;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic              m_valid;
  logic [DATA_W-1:0] m_hi;
  logic [DATA_W-1:0] m_lo;
  bit                m_known;

  ex_mem_hilo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ex_mem_hilo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HILO_RST('0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic rst, input logic [5:0] stall, input logic flush,
                      input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] addr,
                      input logic we, input logic hwe, input logic hsel,
                      input logic rsel, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n                = rst;
    bus.stall_i          = stall;
    bus.flush_i          = flush;
    bus.ex_reg_i         = data;
    bus.ex_reg_w_addr_i  = addr;
    bus.ex_reg_w_en_i    = we;
    bus.ex_hilo_w_en_i   = hwe;
    bus.ex_hilo_w_addr_i = hsel;
    bus.hilo_rd_sel_i    = rsel;
    #1;
    if (m_known) check({tag, "/rdata"}, bus.hilo_rdata_o, rsel ? m_hi : m_lo);

    if (rst) begin
      m_data = '0; m_addr = '0; m_we = 1'b0; m_valid = 1'b0;
      m_hi = '0; m_lo = '0; m_known = 1'b1;
    end else if (flush) begin
      m_data = '0; m_addr = '0; m_we = 1'b0; m_valid = 1'b0;
    end else if (stall[3] && !stall[4]) begin
      m_data = '0; m_addr = '0; m_we = 1'b0; m_valid = 1'b0;
    end else if (!stall[3]) begin
      m_data = data; m_addr = addr; m_we = we; m_valid = 1'b1;
      if (hwe) begin
        if (hsel) m_hi = data;
        else      m_lo = data;
      end
    end
    e = '{data: m_data, addr: m_addr, we: m_we, valid: m_valid, hi: m_hi, lo: m_lo};
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, "/mem_reg"},   bus.mem_reg_o, got.data);
      check({tag, "/mem_addr"},  DATA_W'(bus.mem_reg_w_addr_o), DATA_W'(got.addr));
      check({tag, "/mem_we"},    DATA_W'(bus.mem_reg_w_en_o), DATA_W'(got.we));
      check({tag, "/mem_valid"}, DATA_W'(bus.mem_valid_o), DATA_W'(got.valid));
      check({tag, "/hi"},        bus.hi_o, got.hi);
      check({tag, "/lo"},        bus.lo_o, got.lo);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_known  = 1'b0;
    rst_n    = 1'b1;
    bus.stall_i = '0; bus.flush_i = 1'b0; bus.ex_reg_i = '0;
    bus.ex_reg_w_addr_i = '0; bus.ex_reg_w_en_i = 1'b0;
    bus.ex_hilo_w_en_i = 1'b0; bus.ex_hilo_w_addr_i = 1'b0; bus.hilo_rd_sel_i = 1'b0;

    // Reset with live-looking EX inputs
    step(1'b1, 6'b000000, 1'b0, 32'hDEADBEEF, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, "reset0");
    step(1'b1, 6'b011000, 1'b1, 32'hDEADBEEF, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, "reset1");
    check("reset/hi_const", bus.hi_o, 32'h0);

    step(1'b0, 6'b000000, 1'b0, 32'h12345678, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, "pass");
    check("pass/const_reg", bus.mem_reg_o, 32'h12345678);

    // MTHI then MFHI; GPR enable low, hilo write must not show on mem_we
    step(1'b0, 6'b000000, 1'b0, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, "mthi");
    step(1'b0, 6'b000000, 1'b0, 32'h00000000, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, "mfhi");
    check("mfhi/lo_const", bus.lo_o, 32'h0);
    step(1'b0, 6'b000000, 1'b0, 32'h0BADF00D, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, "mtlo");
    step(1'b0, 6'b000000, 1'b0, 32'h00000001, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, "mflo");

    // EX stalled, MEM free -> bubble, no HI/LO write
    step(1'b0, 6'b001000, 1'b0, 32'h00000011, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, "bubble");
    step(1'b0, 6'b001000, 1'b0, 32'h00000011, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, "bubble2");

    // Capture 0x55 then hold several cycles
    step(1'b0, 6'b000000, 1'b0, 32'h00000055, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, "cap55");
    for (int i = 0; i < 3; i++)
      step(1'b0, 6'b011000, 1'b0, 32'h99 + DATA_W'(i), 5'd1, 1'b0, 1'b1, 1'(i), 1'b1, "hold");
    check("hold/const_reg", bus.mem_reg_o, 32'h55);

    // Flush beats an MTLO, even when stall bits would otherwise capture or hold
    step(1'b0, 6'b000000, 1'b0, 32'h00000066, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, "preflush");
    step(1'b0, 6'b000000, 1'b1, 32'h00000077, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, "flush");
    step(1'b0, 6'b011000, 1'b1, 32'h00000078, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, "flushhold");

    // Irrelevant stall bits are ignored
    step(1'b0, 6'b100111, 1'b0, 32'hCAFEBABE, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, "otherbits");

    // Reset in the same cycle as flush plus MTHI
    step(1'b1, 6'b000000, 1'b1, 32'h12121212, 5'd10, 1'b1, 1'b1, 1'b1, 1'b1, "rstflush");
    step(1'b0, 6'b000000, 1'b0, 32'h34343434, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, "postrst");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [5:0] st;
      st = 6'($urandom);
      if ($urandom_range(0, 1) == 0) st[4:3] = 2'b00;
      step(1'($urandom_range(0, 19) == 0), st, 1'($urandom_range(0, 7) == 0),
           32'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
